vga_pixel_out: RTL

VGA_PIXEL_OUT -- requirements
Module: vga_pixel_out

---
 rtl/vga_pixel_out_pkg.sv | 7 +
 rtl/vga_pixel_out_if.sv | 17 +
 rtl/vga_fade_ctrl.sv | 61 ++++++
 rtl/vga_pixel_out.sv | 67 ++++++
 4 files changed

// File: rtl/vga_pixel_out_pkg.sv
// vga_pixel_out_pkg: shared fade FSM state encoding and channel count.
//   fade_state_t : FULL, FADING_OUT, DARK, FADING_IN
//   NCH          : number of colour channels (R, G, B)
package vga_pixel_out_pkg;
    typedef enum logic [1:0] {FULL, FADING_OUT, DARK, FADING_IN} fade_state_t;
    localparam int NCH = 3;
endpackage

// File: rtl/vga_pixel_out_if.sv
// vga_pixel_out_if: video bus between the timing generator and vga_pixel_out.
//   hen/ven        : horizontal/vertical active-video enables
//   hsync_in/vsync_in, colors_in : raw syncs and {R,G,B} pixel colour
//   colors, hsync, vsync         : aligned, gated and faded outputs
//   master = video source side, slave = vga_pixel_out side
interface vga_pixel_out_if #(parameter int CW = 4);
    logic                                 hen;
    logic                                 ven;
    logic                                 hsync_in;
    logic                                 vsync_in;
    logic [vga_pixel_out_pkg::NCH*CW-1:0] colors_in;
    logic [vga_pixel_out_pkg::NCH*CW-1:0] colors;
    logic                                 hsync;
    logic                                 vsync;
    modport master (output hen, ven, hsync_in, vsync_in, colors_in, input colors, hsync, vsync);
    modport slave (input hen, ven, hsync_in, vsync_in, colors_in, output colors, hsync, vsync);
endinterface

// File: rtl/vga_fade_ctrl.sv
// vga_fade_ctrl: frame-tick counter and fade FSM producing the brightness level.
//   clk25m, rst               : pixel clock, async active-high reset
//   ven                       : raw vertical enable; its 1->0 edge is the frame tick
//   fade_out_req, fade_in_req : single-cycle fade requests (out wins when both high)
//   fade_level                : brightness, 0 = black, all ones = full
//   fade_busy                 : high while fading out or in
module vga_fade_ctrl import vga_pixel_out_pkg::*; #(
    parameter int CW          = 4,
    parameter int STEP_FRAMES = 2
) (
    input  logic          clk25m,
    input  logic          rst,
    input  logic          ven,
    input  logic          fade_out_req,
    input  logic          fade_in_req,
    output logic [CW-1:0] fade_level,
    output logic          fade_busy
);
    localparam logic [CW-1:0] MAX  = '1;
    localparam logic [3:0]    LAST = 4'(STEP_FRAMES - 1);
    fade_state_t state;
    logic        ven_q;
    logic [3:0]  cnt;
    logic        tick, wrap, go_out, go_in;
    assign tick   = ven_q & ~ven;
    assign wrap   = tick && cnt == LAST;
    assign go_out = fade_out_req && (state == FULL || state == FADING_IN);
    // a simultaneous fade_out_req suppresses fade_in_req even where the out request is ignored
    assign go_in  = fade_in_req && !fade_out_req && (state == DARK || state == FADING_OUT);
    always_ff @(posedge clk25m or posedge rst)
        if (rst) begin
            state      <= FULL;
            fade_level <= MAX;
            fade_busy  <= 1'b0;
            cnt        <= '0;
            ven_q      <= 1'b0;
        end else begin
            ven_q <= ven;
            if (go_out || go_in) begin
                state     <= go_out ? FADING_OUT : FADING_IN;
                fade_busy <= 1'b1;
                cnt       <= '0;
            end else if (tick) begin
                cnt <= wrap ? '0 : cnt + 4'd1;
                if (wrap && state == FADING_OUT) begin
                    fade_level <= fade_level - CW'(1);
                    if (fade_level == CW'(1)) begin
                        state     <= DARK;
                        fade_busy <= 1'b0;
                    end
                end
                if (wrap && state == FADING_IN) begin
                    fade_level <= fade_level + CW'(1);
                    if (fade_level == MAX - CW'(1)) begin
                        state     <= FULL;
                        fade_busy <= 1'b0;
                    end
                end
            end
        end
endmodule

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: delays video by DELAY clocks, blanks outside active video, applies fade.
//   clk25m, rst               : pixel clock, async active-high reset
//   vid (slave)               : video bus in/out, see vga_pixel_out_if
//   fade_out_req, fade_in_req : fade requests forwarded to vga_fade_ctrl
//   fade_busy, fade_level     : fade status
module vga_pixel_out import vga_pixel_out_pkg::*; #(
    parameter int CW          = 4,
    parameter int DELAY       = 1,
    parameter int STEP_FRAMES = 2
) (
    input  logic            clk25m,
    input  logic            rst,
    vga_pixel_out_if.slave  vid,
    input  logic            fade_out_req,
    input  logic            fade_in_req,
    output logic            fade_busy,
    output logic [CW-1:0]   fade_level
);
    localparam int            W   = NCH * CW + 4;
    localparam logic [CW-1:0] MAX = '1;
    logic [W-1:0]      din, tap;
    logic [CW-1:0]     dim;
    logic [NCH*CW-1:0] shaded;
    vga_fade_ctrl #(.CW(CW), .STEP_FRAMES(STEP_FRAMES)) u_fade (
        .clk25m      (clk25m),
        .rst         (rst),
        .ven         (vid.ven),
        .fade_out_req(fade_out_req),
        .fade_in_req (fade_in_req),
        .fade_level  (fade_level),
        .fade_busy   (fade_busy)
    );
    assign din = {vid.hen, vid.ven, vid.hsync_in, vid.vsync_in, vid.colors_in};
    // DELAY-1 raw stages; the output register below is the final stage
    for (genvar i = 0; i < DELAY - 1; i++) begin : g_stage
        logic [W-1:0] q;
        if (i == 0) begin : g_first
            always_ff @(posedge clk25m or posedge rst)
                if (rst) q <= '0;
                else q <= din;
        end else begin : g_next
            always_ff @(posedge clk25m or posedge rst)
                if (rst) q <= '0;
                else q <= g_stage[i-1].q;
        end
    end
    if (DELAY == 1) begin : g_tap_direct
        assign tap = din;
    end else begin : g_tap_stage
        assign tap = g_stage[DELAY-2].q;
    end
    // subtracting (MAX - level) per channel, clamped at 0, gives a linear fade to black
    assign dim = MAX - fade_level;
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign shaded[c*CW +: CW] = (tap[W-1] && tap[W-2] && tap[c*CW +: CW] > dim) ? tap[c*CW +: CW] - dim : '0;
    end
    always_ff @(posedge clk25m or posedge rst)
        if (rst) begin
            vid.colors <= '0;
            vid.hsync  <= 1'b0;
            vid.vsync  <= 1'b0;
        end else begin
            vid.colors <= shaded;
            vid.hsync  <= tap[W-3];
            vid.vsync  <= tap[W-4];
        end
endmodule
